// File: rtl/tube_pkg.sv
// Shared definitions for the LED tube display arbiter.
package tube_pkg;

   // Width of one display word handed to the tube scanner.
   localparam int DATA_W = 32;

   // Arbiter FSM state encoding.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DWELL = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // Grouped view of the arbiter state, handy for probing in simulation.
   typedef struct packed {
      logic [1:0] state;
      logic       pinned;
   } tube_dbg_t;

endpackage

// File: rtl/tube_rr_picker.sv
// Combinational round-robin picker: returns the first requester after
// last_owner (wrapping), optionally skipping one excluded index.
module tube_rr_picker
   import tube_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int SEL_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] last_owner,
   input  logic [SEL_W-1:0] exclude,
   input  logic             exclude_en,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   localparam logic [SEL_W:0] NREQ_W = (SEL_W+1)'(NREQ);

   // Scan last_owner+1, +2, ... modulo NREQ and keep the first eligible hit.
   always_comb begin
      logic [SEL_W:0]   sum;
      logic [SEL_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         sum = {1'b0, last_owner} + (SEL_W+1)'(k);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         cand = sum[SEL_W-1:0];
         if (!found && req[cand] && !(exclude_en && (cand == exclude))) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/tube_display_arbiter.sv
// Shares one 8-digit LED tube between NREQ requesters with round-robin
// ownership, a minimum dwell time per owner and a debug pin mode.
//
// Request protocol: req[i] is a level, not a pulse. A requester raises it and
// holds it for as long as it wants the display; it sees grant[i] one cycle
// after req[i] is sampled and must keep req_data word i valid while req[i]=1.
// Dropping req[i] releases the claim; the display keeps showing the last word
// until the minimum dwell has elapsed.
module tube_display_arbiter
   import tube_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DWELL_CYCLES = 25_000_000,
   parameter int CNT_W        = 25,
   parameter int SEL_W        = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic                   pin_en,
   input  logic [SEL_W-1:0]       pin_sel,
   output logic [NREQ-1:0]        grant,
   output logic [DATA_W-1:0]      disp_data,
   output logic [SEL_W-1:0]       disp_src,
   output logic                   disp_valid
);

   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NREQ - 1);

   logic [1:0]        state_q,  state_d;
   logic [SEL_W-1:0]  owner_q,  owner_d;
   logic [SEL_W-1:0]  last_q,   last_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              pinned_q;
   logic [NREQ-1:0]   grant_d;
   logic              pick_found;
   logic [SEL_W-1:0]  pick_idx;
   logic              excl_en;
   logic              show_d;
   logic              load_d;
   logic [DATA_W-1:0] words [NREQ];
   tube_dbg_t         dbg;

   // FSM state in one probe-friendly bundle.
   assign dbg = '{state: state_q, pinned: pinned_q};

   // Slice the flat request bus into per-requester words.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         words[i] = req_data[DATA_W*i +: DATA_W];
      end
   end

   // While someone owns the display, the owner itself never counts as "other pending".
   assign excl_en = (state_q != ST_IDLE);

   tube_rr_picker #(
      .NREQ  (NREQ),
      .SEL_W (SEL_W)
   ) u_picker (
      .req        (req),
      .last_owner (last_q),
      .exclude    (owner_q),
      .exclude_en (excl_en),
      .found      (pick_found),
      .idx        (pick_idx)
   );

   // Next-state logic: pin mode overrides arbitration, leaving pin reloads the dwell.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (pin_en) begin
         state_d = ST_DWELL;
         owner_d = pin_sel;
         last_d  = pin_sel;
         cnt_d   = RELOAD;
      end else if (pinned_q) begin
         state_d = ST_DWELL;
         cnt_d   = RELOAD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  state_d = ST_DWELL;
                  owner_d = pick_idx;
                  last_d  = pick_idx;
                  cnt_d   = RELOAD;
               end
            end
            ST_DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (pick_found) begin
                  owner_d = pick_idx;
                  last_d  = pick_idx;
                  cnt_d   = RELOAD;
               end else if (req[owner_q]) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (pick_found) begin
                  state_d = ST_DWELL;
                  owner_d = pick_idx;
                  last_d  = pick_idx;
                  cnt_d   = RELOAD;
               end else if (!req[owner_q]) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output intent for the coming cycle, aligned with the next owner.
   always_comb begin
      show_d  = (state_d != ST_IDLE);
      load_d  = show_d && (pin_en || req[owner_d]);
      grant_d = '0;
      if (show_d && req[owner_d]) begin
         grant_d[owner_d] = 1'b1;
      end
   end

   // State and registered outputs; data and source freeze when nothing new is shown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         last_q     <= LAST_RST;
         cnt_q      <= '0;
         pinned_q   <= 1'b0;
         grant      <= '0;
         disp_data  <= '0;
         disp_src   <= '0;
         disp_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         pinned_q   <= pin_en;
         grant      <= grant_d;
         disp_valid <= show_d;
         if (show_d) begin
            disp_src <= owner_d;
         end
         if (load_d) begin
            disp_data <= words[owner_d];
         end
      end
   end

endmodule
